// File: rtl/write_pkg.sv
// Shared constants, FSM encoding and entry packing for the packet-buffer producer.
package write_pkg;

  localparam int unsigned DEPTH   = 6;
  localparam int unsigned ENTRY_W = 3;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned BUF_W   = DEPTH * ENTRY_W;
  localparam int unsigned NUM_BUF = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned DATA_W  = 2;
  localparam int unsigned ST_W    = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_ID0    = 3'd1;
  localparam logic [ST_W-1:0] ST_ID1    = 3'd2;
  localparam logic [ST_W-1:0] ST_D0     = 3'd3;
  localparam logic [ST_W-1:0] ST_D1     = 3'd4;
  localparam logic [ST_W-1:0] ST_PAR    = 3'd5;
  localparam logic [ST_W-1:0] ST_COMMIT = 3'd6;

  localparam logic [ID_W-1:0] BUF1_ID = 2'd0;
  localparam logic [ID_W-1:0] BUF2_ID = 2'd1;
  localparam logic [ID_W-1:0] BUF3_ID = 2'd2;
  localparam logic [ID_W-1:0] BUF4_ID = 2'd3;

  // Entry layout: data in the upper bits, valid flag in bit 0.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DATA_W-1:0] data);
    return {data, 1'b1};
  endfunction

endpackage

// File: rtl/write_if.sv
// Serial input, pop strobes and buffer/status outputs of the packet-buffer producer.
interface write_if;
  import write_pkg::*;

  logic                   bit_in;
  logic                   bit_valid;
  logic [NUM_BUF-1:0]     pop;
  logic [BUF_W-1:0]       buffer1_o;
  logic [BUF_W-1:0]       buffer2_o;
  logic [BUF_W-1:0]       buffer3_o;
  logic [BUF_W-1:0]       buffer4_o;
  logic [CNT_W-1:0]       cnt1;
  logic [CNT_W-1:0]       cnt2;
  logic [CNT_W-1:0]       cnt3;
  logic [CNT_W-1:0]       cnt4;
  logic                   busy;
  logic                   drop;
  logic                   perr;

  modport master (
    output bit_in, bit_valid, pop,
    input  buffer1_o, buffer2_o, buffer3_o, buffer4_o,
    input  cnt1, cnt2, cnt3, cnt4, busy, drop, perr
  );

  modport slave (
    input  bit_in, bit_valid, pop,
    output buffer1_o, buffer2_o, buffer3_o, buffer4_o,
    output cnt1, cnt2, cnt3, cnt4, busy, drop, perr
  );

endinterface

// File: rtl/write_frame_deser.sv
// Serial frame deserialiser: start, id[1:0], data[1:0], even parity; one-cycle result in COMMIT.
module frame_deser
  import write_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic              frm_valid,
  output logic [ID_W-1:0]   frm_id,
  output logic [DATA_W-1:0] frm_data,
  output logic              frm_perr
);

  logic [ST_W-1:0]        state_q, state_d;
  logic [ID_W+DATA_W-1:0] shift_q, shift_d;
  logic                   valid_d, perr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      frm_valid <= 1'b0;
      frm_perr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      frm_valid <= valid_d;
      frm_perr  <= perr_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Advance only on strobed bits; COMMIT always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (bit_valid && bit_in) state_d = ST_ID0;
      ST_ID0:  if (bit_valid) begin shift_d = {shift_q[2:0], bit_in}; state_d = ST_ID1; end
      ST_ID1:  if (bit_valid) begin shift_d = {shift_q[2:0], bit_in}; state_d = ST_D0;  end
      ST_D0:   if (bit_valid) begin shift_d = {shift_q[2:0], bit_in}; state_d = ST_D1;  end
      ST_D1:   if (bit_valid) begin shift_d = {shift_q[2:0], bit_in}; state_d = ST_PAR; end
      ST_PAR: begin
        if (bit_valid) begin
          state_d = ST_COMMIT;
          valid_d = 1'b1;
          perr_d  = bit_in ^ (^shift_q);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign frm_id   = shift_q[3:2];
  assign frm_data = shift_q[1:0];

endmodule

// File: rtl/write.sv
// Packet-buffer producer: deserialised frames appended to four buffers, scheduler pops merged in.
module write
  import write_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  write_if.slave bus
);

  logic              frm_valid, frm_perr, busy;
  logic [ID_W-1:0]   frm_id;
  logic [DATA_W-1:0] frm_data;

  logic [BUF_W-1:0] buf_q [NUM_BUF];
  logic [BUF_W-1:0] buf_d [NUM_BUF];
  logic [CNT_W-1:0] cnt_q [NUM_BUF];
  logic [CNT_W-1:0] cnt_d [NUM_BUF];
  logic             drop_q, drop_d;
  logic             perr_q;

  frame_deser u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bus.bit_in),
    .bit_valid (bus.bit_valid),
    .busy      (busy),
    .frm_valid (frm_valid),
    .frm_id    (frm_id),
    .frm_data  (frm_data),
    .frm_perr  (frm_perr)
  );

  // Pop shifts first, then a good frame lands at the post-pop tail.
  always_comb begin
    drop_d = 1'b0;
    for (int k = 0; k < NUM_BUF; k++) begin
      buf_d[k] = buf_q[k];
      cnt_d[k] = cnt_q[k];
      if (bus.pop[k] && (cnt_q[k] != '0)) begin
        buf_d[k] = buf_q[k] >> ENTRY_W;
        cnt_d[k] = cnt_q[k] - CNT_W'(1);
      end
      if (frm_valid && !frm_perr && (frm_id == ID_W'(k))) begin
        if (cnt_d[k] == CNT_W'(DEPTH)) begin
          drop_d = 1'b1;
        end else begin
          for (int s = 0; s < DEPTH; s++) begin
            if (cnt_d[k] == CNT_W'(s)) buf_d[k][s*ENTRY_W +: ENTRY_W] = pack_entry(frm_data);
          end
          cnt_d[k] = cnt_d[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BUF; k++) begin
        buf_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      drop_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_BUF; k++) begin
        buf_q[k] <= buf_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      drop_q <= drop_d;
      perr_q <= frm_valid && frm_perr;
    end
  end

  assign bus.buffer1_o = buf_q[0];
  assign bus.buffer2_o = buf_q[1];
  assign bus.buffer3_o = buf_q[2];
  assign bus.buffer4_o = buf_q[3];
  assign bus.cnt1      = cnt_q[0];
  assign bus.cnt2      = cnt_q[1];
  assign bus.cnt3      = cnt_q[2];
  assign bus.cnt4      = cnt_q[3];
  assign bus.busy      = busy;
  assign bus.drop      = drop_q;
  assign bus.perr      = perr_q;

endmodule

// File: tb/tb_write.sv
// Directed bench for the packet-buffer producer with hand-computed expectations.
module tb_write;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  write_if wif();

  write dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives bits back-to-back MSB first; returns at the negedge inside COMMIT.
  task automatic send_frame(input logic [5:0] f);
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      wif.bit_valid = 1'b1;
      wif.bit_in    = f[i];
    end
    @(negedge clk);
    wif.bit_valid = 1'b0;
    wif.bit_in    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    wif.bit_in    = 1'b0;
    wif.bit_valid = 1'b0;
    wif.pop       = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_buf1", 32'(wif.buffer1_o), 32'h0);
    check("rst_cnt4", 32'(wif.cnt4), 32'h0);
    check("rst_flags", {29'h0, wif.busy, wif.drop, wif.perr}, 32'h0);

    // id 10 data 11 parity 1 -> buffer3 slot0 = 111, one clock after the parity bit
    send_frame(6'b110111);
    check("t1_busy_commit", 32'(wif.busy), 32'h1);
    check("t1_cnt3_early", 32'(wif.cnt3), 32'h0);
    @(negedge clk);
    check("t1_buf3", 32'(wif.buffer3_o), 32'h00007);
    check("t1_cnt3", 32'(wif.cnt3), 32'h1);
    check("t1_others", 32'(wif.buffer1_o | wif.buffer2_o | wif.buffer4_o), 32'h0);
    check("t1_busy_idle", 32'(wif.busy), 32'h0);

    // Fill buffer1 with six 011 entries, seventh is dropped
    do_reset();
    for (int n = 0; n < 6; n++) send_frame(6'b100011);
    @(negedge clk);
    check("t2_buf1_full", 32'(wif.buffer1_o), 32'h1B6DB);
    check("t2_cnt1_full", 32'(wif.cnt1), 32'h6);
    send_frame(6'b100011);
    check("t2_no_drop_yet", 32'(wif.drop), 32'h0);
    @(negedge clk);
    check("t2_drop", 32'(wif.drop), 32'h1);
    check("t2_buf1_kept", 32'(wif.buffer1_o), 32'h1B6DB);
    check("t2_cnt1_kept", 32'(wif.cnt1), 32'h6);
    @(negedge clk);
    check("t2_drop_pulse", 32'(wif.drop), 32'h0);

    // Bad parity: id 00 data 00 parity 1
    send_frame(6'b100001);
    @(negedge clk);
    check("t3_perr", 32'(wif.perr), 32'h1);
    check("t3_busy", 32'(wif.busy), 32'h0);
    check("t3_buf1", 32'(wif.buffer1_o), 32'h1B6DB);
    check("t3_cnt1", 32'(wif.cnt1), 32'h6);
    check("t3_cnt_others", 32'({wif.cnt2, wif.cnt3, wif.cnt4}), 32'h0);
    @(negedge clk);
    check("t3_perr_pulse", 32'(wif.perr), 32'h0);

    // Full buffer1 popped while committing data 10: write accepted at top slot
    send_frame(6'b100101);
    wif.pop = 4'b0001;
    @(negedge clk);
    wif.pop = 4'b0000;
    check("t3b_buf1", 32'(wif.buffer1_o), 32'h2B6DB);
    check("t3b_cnt1", 32'(wif.cnt1), 32'h6);
    check("t3b_drop", 32'(wif.drop), 32'h0);

    // Buffer2 holds 011,101; data 11 committed with a same-cycle pop
    do_reset();
    send_frame(6'b101010);
    send_frame(6'b101100);
    @(negedge clk);
    check("t4_buf2_pre", 32'(wif.buffer2_o), 32'h0002B);
    check("t4_cnt2_pre", 32'(wif.cnt2), 32'h2);
    send_frame(6'b101111);
    wif.pop = 4'b0010;
    @(negedge clk);
    wif.pop = 4'b0000;
    check("t4_buf2", 32'(wif.buffer2_o), 32'h0003D);
    check("t4_cnt2", 32'(wif.cnt2), 32'h2);

    // Pop on empty buffers, then load and pop buffer4
    do_reset();
    @(negedge clk);
    wif.pop = 4'b1111;
    @(negedge clk);
    wif.pop = 4'b0000;
    check("t5_empty_bufs", 32'(wif.buffer1_o | wif.buffer2_o | wif.buffer3_o | wif.buffer4_o), 32'h0);
    check("t5_empty_cnts", 32'({wif.cnt1, wif.cnt2, wif.cnt3, wif.cnt4}), 32'h0);
    send_frame(6'b111101);
    @(negedge clk);
    check("t5_buf4_load", 32'(wif.buffer4_o), 32'h00005);
    check("t5_cnt4_load", 32'(wif.cnt4), 32'h1);
    wif.pop = 4'b1000;
    @(negedge clk);
    wif.pop = 4'b0000;
    check("t5_buf4_pop", 32'(wif.buffer4_o), 32'h0);
    check("t5_cnt4_pop", 32'(wif.cnt4), 32'h0);

    // Reset after three frame bits discards the partial frame
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wif.bit_valid = 1'b1;
      wif.bit_in    = (i != 1);
    end
    @(negedge clk);
    wif.bit_valid = 1'b0;
    check("t6_busy_mid", 32'(wif.busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_busy_rst", 32'(wif.busy), 32'h0);
    send_frame(6'b101010);
    @(negedge clk);
    check("t6_cnt2", 32'(wif.cnt2), 32'h1);
    check("t6_buf2", 32'(wif.buffer2_o), 32'h00003);
    check("t6_flags", {30'h0, wif.drop, wif.perr}, 32'h0);
    check("t6_cnt_others", 32'({wif.cnt1, wif.cnt3, wif.cnt4}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
